// File: rtl/wb_slave_ram.sv
// Wishbone classic RAM slave: programmable wait states and byte-lane writes.
// Define WB_SLAVE_RAM_ERR_EN to terminate out-of-range accesses with err_o.
module wb_slave_ram #(
   parameter int ADR_WIDTH   = 16,
   parameter int DAT_WIDTH   = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cyc_i,
   input  logic                   stb_i,
   input  logic                   we_i,
   input  logic [ADR_WIDTH-1:0]   adr_i,
   input  logic [DAT_WIDTH/8-1:0] sel_i,
   input  logic [DAT_WIDTH-1:0]   dat_i,
   output logic [DAT_WIDTH-1:0]   dat_o,
   output logic                   ack_o
`ifdef WB_SLAVE_RAM_ERR_EN
   ,
   output logic                   err_o
`endif
);

   localparam int NB  = DAT_WIDTH / 8;
   localparam int OFS = $clog2(NB);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 we_q, we_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [NB-1:0]        sel_q, sel_d;
   logic [DAT_WIDTH-1:0] wdat_q, wdat_d;
   logic                 ack_q, ack_d;
   logic [DAT_WIDTH-1:0] rdat_q, rdat_d;
   logic                 enter_ack;
   logic                 in_rng;
   logic                 hit;
   logic                 unused_adr;

   logic [DAT_WIDTH-1:0] mem_q [DEPTH];

   // Only the word-index bits are decoded; the rest belong to the interconnect.
   assign unused_adr = ^adr_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      idx_d     = idx_q;
      sel_d     = sel_q;
      wdat_d    = wdat_q;
      enter_ack = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cyc_i && stb_i) begin
               we_d   = we_i;
               idx_d  = adr_i[OFS+IW-1:OFS];
               sel_d  = sel_i;
               wdat_d = dat_i;
               cnt_d  = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d   = S_ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!cyc_i) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q <= 4'd1) begin
               state_d   = S_ACK;
               cnt_d     = 4'd0;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The *_d request fields hold the active request on the edge entering ACK,
   // whether it was captured earlier or arrives with zero wait states.
   assign in_rng = (32'(idx_d) < DEPTH);
   assign hit    = enter_ack && in_rng;
   assign rdat_d = (hit && !we_d) ? mem_q[idx_d] : '0;

`ifdef WB_SLAVE_RAM_ERR_EN
   logic err_q, err_d;
   assign ack_d = hit;
   assign err_d = enter_ack && !in_rng;
   assign err_o = err_q;
`else
   assign ack_d = enter_ack;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         sel_q   <= '0;
         wdat_q  <= '0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
`ifdef WB_SLAVE_RAM_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
`ifdef WB_SLAVE_RAM_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && hit && we_d) begin
         for (int b = 0; b < NB; b++) begin
            if (sel_d[b]) mem_q[idx_d][8*b +: 8] <= wdat_d[8*b +: 8];
         end
      end
   end

   assign ack_o = ack_q;
   assign dat_o = rdat_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: four instances cover the wait-state,
// zero-wait, abort, reset and out-of-range cases.
module tb_wb_slave_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  cyc;
   logic [3:0]  stb;
   logic        we;
   logic [15:0] adr;
   logic [3:0]  sel;
   logic [31:0] wdat;
   logic [31:0] rd  [4];
   logic        ack [4];
   logic        err [4];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_slave_ram #(.WAIT_STATES(1), .DEPTH(256)) u0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]),
      .we_i(we), .adr_i(adr), .sel_i(sel), .dat_i(wdat),
      .dat_o(rd[0]), .ack_o(ack[0])
`ifdef WB_SLAVE_RAM_ERR_EN
      , .err_o(err[0])
`endif
   );

   wb_slave_ram #(.WAIT_STATES(3), .DEPTH(256)) u1 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]),
      .we_i(we), .adr_i(adr), .sel_i(sel), .dat_i(wdat),
      .dat_o(rd[1]), .ack_o(ack[1])
`ifdef WB_SLAVE_RAM_ERR_EN
      , .err_o(err[1])
`endif
   );

   wb_slave_ram #(.WAIT_STATES(0), .DEPTH(256)) u2 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]),
      .we_i(we), .adr_i(adr), .sel_i(sel), .dat_i(wdat),
      .dat_o(rd[2]), .ack_o(ack[2])
`ifdef WB_SLAVE_RAM_ERR_EN
      , .err_o(err[2])
`endif
   );

   wb_slave_ram #(.WAIT_STATES(1), .DEPTH(200)) u3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[3]), .stb_i(stb[3]),
      .we_i(we), .adr_i(adr), .sel_i(sel), .dat_i(wdat),
      .dat_o(rd[3]), .ack_o(ack[3])
`ifdef WB_SLAVE_RAM_ERR_EN
      , .err_o(err[3])
`endif
   );

`ifndef WB_SLAVE_RAM_ERR_EN
   assign err[0] = 1'b0;
   assign err[1] = 1'b0;
   assign err[2] = 1'b0;
   assign err[3] = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transfer; inputs are scrambled after capture to prove they are latched.
   task automatic xfer(input int id, input logic w, input logic [15:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] q, output int lat,
                       output logic e);
      we = w; adr = a; sel = s; wdat = d;
      cyc[id] = 1'b1; stb[id] = 1'b1;
      lat = 0; q = '0; e = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (ack[id] || err[id]) begin
            lat = i; q = rd[id]; e = err[id];
            break;
         end
         we = ~w; adr = ~a; sel = ~s; wdat = ~d;
      end
      cyc[id] = 1'b0; stb[id] = 1'b0;
      @(posedge clk); #1;
      chk("term_width", {ack[id], err[id]}, 2'b00);
      chk("dat_clear", rd[id], 32'h0);
   endtask

   logic [31:0] q;
   int          lat;
   logic        e;
   int          nack;
   int          dbad;
   logic [7:0]  pat;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cyc = '0; stb = '0;
      we = 1'b0; adr = '0; sel = '0; wdat = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack_u0", ack[0], 1'b0);
      chk("rst_dat_u0", rd[0], 32'h0);
      chk("rst_ack_u2", ack[2], 1'b0);
      chk("rst_dat_u3", rd[3], 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      xfer(0, 1'b1, 16'h0004, 4'hF, 32'hDEADBEEF, q, lat, e);
      chk("t1_wr_lat", lat, 2);
      xfer(0, 1'b0, 16'h0004, 4'h0, 32'h0, q, lat, e);
      chk("t1_rd_lat", lat, 2);
      chk("t1_rd_dat", q, 32'hDEADBEEF);

      xfer(0, 1'b1, 16'h0008, 4'hF, 32'h11223344, q, lat, e);
      xfer(0, 1'b1, 16'h0008, 4'b0101, 32'hAABBCCDD, q, lat, e);
      xfer(0, 1'b0, 16'h0008, 4'h0, 32'h0, q, lat, e);
      chk("t2_lanes", q, 32'h11BB33DD);

      xfer(1, 1'b1, 16'h000C, 4'hF, 32'h55667788, q, lat, e);
      chk("t3_wr_lat", lat, 4);
      we = 1'b1; adr = 16'h000C; sel = 4'hF; wdat = 32'hCAFEF00D;
      cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb[1] = 1'b0;
      nack = 0;
      repeat (6) begin
         @(posedge clk); #1;
         nack += int'(ack[1]);
      end
      chk("t3_abort_ack", nack, 0);
      xfer(1, 1'b0, 16'h000C, 4'h0, 32'h0, q, lat, e);
      chk("t3_rd_lat", lat, 4);
      chk("t3_rd_dat", q, 32'h55667788);

      xfer(2, 1'b1, 16'h0010, 4'hF, 32'h0BADCAFE, q, lat, e);
      chk("t4_wr_lat", lat, 1);
      we = 1'b0; adr = 16'h0010; sel = 4'h0; wdat = '0;
      cyc[2] = 1'b1; stb[2] = 1'b1;
      pat = '0; dbad = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         pat = {pat[6:0], ack[2]};
         if (rd[2] !== (ack[2] ? 32'h0BADCAFE : 32'h0)) dbad++;
      end
      cyc[2] = 1'b0; stb[2] = 1'b0;
      @(posedge clk); #1;
      chk("t4_ack_pat", pat, 8'hAA);
      chk("t4_dat_bad", dbad, 0);

      xfer(3, 1'b1, 16'h0000, 4'hF, 32'h12345678, q, lat, e);
      xfer(3, 1'b1, 16'h0320, 4'hF, 32'hFFFFFFFF, q, lat, e);
      chk("t5_wr_lat", lat, 2);
`ifdef WB_SLAVE_RAM_ERR_EN
      chk("t5_wr_err", e, 1'b1);
`else
      chk("t5_wr_err", e, 1'b0);
`endif
      xfer(3, 1'b0, 16'h0320, 4'h0, 32'h0, q, lat, e);
      chk("t5_rd_lat", lat, 2);
      chk("t5_rd_dat", q, 32'h0);
      xfer(3, 1'b0, 16'h0000, 4'h0, 32'h0, q, lat, e);
      chk("t5_word0", q, 32'h12345678);

      xfer(0, 1'b1, 16'h0014, 4'hF, 32'h01020304, q, lat, e);
      we = 1'b1; adr = 16'h0014; sel = 4'hF; wdat = 32'hFFFF0000;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_rst_ack", ack[0], 1'b0);
      chk("t6_rst_dat", rd[0], 32'h0);
      rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #1;
      xfer(0, 1'b0, 16'h0014, 4'h0, 32'h0, q, lat, e);
      chk("t6_rd_lat", lat, 2);
      chk("t6_rd_dat", q, 32'h01020304);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
